codec_cfg_sequencer: RTL

CODEC_CFG_SEQUENCER -- requirements
Module: codec_cfg_sequencer

---
 rtl/codec_cfg_sequencer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/codec_cfg_sequencer.sv
// Codec configuration sequencer: sends an 11-entry init table, or single register writes,
// as 3-byte I2C-style frames. Define CFG_RETRY_EN to re-send NACKed frames up to MAX_RETRY times.
module codec_cfg_sequencer #(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         MAX_RETRY = 3
) (
  input  logic       i2c_sclk_o,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       start_cf_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [6:0] req_addr_i,
  input  logic [8:0] req_data_i,
  output logic       busy_o,
  output logic       cf_done_o,
  output logic       err_o,
  output logic [3:0] fsm_state_o
);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_LOAD  = 4'd1;
  localparam logic [3:0] ST_START = 4'd2;
  localparam logic [3:0] ST_BIT   = 4'd3;
  localparam logic [3:0] ST_ACK   = 4'd4;
  localparam logic [3:0] ST_STOP  = 4'd5;
  localparam logic [3:0] ST_GAP   = 4'd6;
  localparam logic [3:0] ST_ERR   = 4'd7;
  localparam logic [3:0] LAST_IDX = 4'd10;

`ifdef CFG_RETRY_EN
  localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);
`else
  // Retries compiled out: the first NACK is final whatever MAX_RETRY says.
  localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY) & 8'h00;
`endif

  function automatic logic [15:0] cfg_entry(input logic [3:0] idx);
    logic [15:0] e;
    case (idx)
      4'd0:    e = {7'd15, 9'h000};
      4'd1:    e = {7'd0,  9'h017};
      4'd2:    e = {7'd1,  9'h017};
      4'd3:    e = {7'd2,  9'h079};
      4'd4:    e = {7'd3,  9'h079};
      4'd5:    e = {7'd4,  9'h012};
      4'd6:    e = {7'd5,  9'h000};
      4'd7:    e = {7'd6,  9'h000};
      4'd8:    e = {7'd7,  9'h00A};
      4'd9:    e = {7'd8,  9'h000};
      4'd10:   e = {7'd9,  9'h001};
      default: e = 16'h0000;
    endcase
    return e;
  endfunction

  logic [3:0]  state_r, state_s;
  logic [3:0]  idx_r, idx_s;
  logic [7:0]  retry_r, retry_s;
  logic [2:0]  bit_r, bit_s;
  logic [1:0]  byte_r, byte_s;
  logic [23:0] shreg_r, shreg_s;
  logic [15:0] req_word_r, req_word_s;
  logic        mode_req_r, mode_req_s;
  logic        nack_r, nack_s;
  logic        cf_done_r, cf_done_s;
  logic        err_r, err_s;
  logic        sda_oe_r, sda_oe_s;
  logic        busy_r, busy_s;
  logic        idle_rdy_r;

  // idle_rdy_r keeps the handshake closed until the first clock after reset.
  assign req_ready_o = idle_rdy_r & en_i & req_valid_i & ~start_cf_i;
  assign sda_oe_o    = sda_oe_r;
  assign busy_o      = busy_r;
  assign cf_done_o   = cf_done_r;
  assign err_o       = err_r;
  assign fsm_state_o = state_r;

  // Next-state, frame datapath and next values of the registered outputs.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    retry_s    = retry_r;
    bit_s      = bit_r;
    byte_s     = byte_r;
    shreg_s    = shreg_r;
    req_word_s = req_word_r;
    mode_req_s = mode_req_r;
    nack_s     = nack_r;
    cf_done_s  = cf_done_r;
    err_s      = err_r;
    case (state_r)
      ST_IDLE: begin
        if (en_i && start_cf_i) begin
          state_s    = ST_LOAD;
          mode_req_s = 1'b0;
          retry_s    = 8'd0;
          cf_done_s  = 1'b0;
          err_s      = 1'b0;
        end else if (req_ready_o) begin
          state_s    = ST_LOAD;
          mode_req_s = 1'b1;
          req_word_s = {req_addr_i, req_data_i};
          retry_s    = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_s = ST_START;
        shreg_s = {DEV_ADDR, 1'b0, (mode_req_r ? req_word_r : cfg_entry(idx_r))};
        bit_s   = 3'd7;
        byte_s  = 2'd0;
        nack_s  = 1'b0;
      end
      ST_START: begin
        state_s = ST_BIT;
      end
      ST_BIT: begin
        shreg_s = {shreg_r[22:0], 1'b0};
        if (bit_r == 3'd0) begin
          state_s = ST_ACK;
        end else begin
          bit_s = bit_r - 3'd1;
        end
      end
      ST_ACK: begin
        if (sda_i) begin
          nack_s  = 1'b1;
          state_s = ST_STOP;
        end else if (byte_r == 2'd2) begin
          state_s = ST_STOP;
        end else begin
          byte_s  = byte_r + 2'd1;
          bit_s   = 3'd7;
          state_s = ST_BIT;
        end
      end
      ST_STOP: begin
        state_s = ST_GAP;
      end
      ST_GAP: begin
        if (nack_r) begin
          if (retry_r == RETRY_LIMIT) begin
            state_s = ST_ERR;
            err_s   = 1'b1;
          end else begin
            retry_s = retry_r + 8'd1;
            state_s = en_i ? ST_LOAD : ST_IDLE;
          end
        end else if (mode_req_r) begin
          retry_s = 8'd0;
          state_s = ST_IDLE;
        end else if (idx_r == LAST_IDX) begin
          retry_s   = 8'd0;
          idx_s     = 4'd0;
          cf_done_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          // Index advances even when pausing, so a later start resumes at the next entry.
          retry_s = 8'd0;
          idx_s   = idx_r + 4'd1;
          state_s = en_i ? ST_LOAD : ST_IDLE;
        end
      end
      ST_ERR: begin
        if (en_i && start_cf_i) begin
          state_s    = ST_LOAD;
          idx_s      = 4'd0;
          mode_req_s = 1'b0;
          retry_s    = 8'd0;
          cf_done_s  = 1'b0;
          err_s      = 1'b0;
        end else begin
          state_s = ST_ERR;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (state_s == ST_BIT) begin
      sda_oe_s = ~shreg_s[23];
    end else begin
      sda_oe_s = (state_s == ST_START) || (state_s == ST_STOP);
    end
    busy_s = (state_s != ST_IDLE) && (state_s != ST_ERR);
  end

  // State, datapath and output registers; reset forces the bus released immediately.
  always_ff @(posedge i2c_sclk_o or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      idx_r      <= 4'd0;
      retry_r    <= 8'd0;
      bit_r      <= 3'd0;
      byte_r     <= 2'd0;
      shreg_r    <= 24'd0;
      req_word_r <= 16'd0;
      mode_req_r <= 1'b0;
      nack_r     <= 1'b0;
      cf_done_r  <= 1'b0;
      err_r      <= 1'b0;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      idle_rdy_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      retry_r    <= retry_s;
      bit_r      <= bit_s;
      byte_r     <= byte_s;
      shreg_r    <= shreg_s;
      req_word_r <= req_word_s;
      mode_req_r <= mode_req_s;
      nack_r     <= nack_s;
      cf_done_r  <= cf_done_s;
      err_r      <= err_s;
      sda_oe_r   <= sda_oe_s;
      busy_r     <= busy_s;
      idle_rdy_r <= (state_s == ST_IDLE);
    end
  end

endmodule
